// File: rtl/cla_add_pipe_if.sv
// cla_add_pipe_if: handshake bundle for the pipelined CLA adder/subtractor.
//   in_valid/in_ready : operation offer / accept
//   in_a, in_b        : operands (WIDTH bits)
//   c_i, sub          : carry/borrow-in and subtract select
//   out_valid/out_ready : result present / consumed
//   out, c_o, ovf     : sum, MSB carry-out, signed overflow
// master = producer/consumer side, slave = the adder.
interface cla_add_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             c_i;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             c_o;
  logic             ovf;

  modport master (
    output in_valid, in_a, in_b, c_i, sub, out_ready,
    input  in_ready, out_valid, out, c_o, ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, c_i, sub, out_ready,
    output in_ready, out_valid, out, c_o, ovf
  );
endinterface

// File: rtl/cla_add_pipe.sv
// cla_add_pipe: pipelined carry-lookahead adder/subtractor.
// The WIDTH-bit operation is split into 4-bit lookahead groups; each of the
// NSTAGE = WIDTH/(4*STAGE_GROUPS) stages resolves STAGE_GROUPS groups and
// registers the group carry for the next stage. Unresolved operand bits move
// forward with the operation, resolved sum bits accumulate behind it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cla_add_pipe_if.slave (valid/ready in, valid/ready out)
// The last stage register is the output register; in_ready = !out_valid ||
// out_ready, the only combinational input-to-output path.
module cla_add_pipe #(
  parameter int WIDTH        = 32,
  parameter int STAGE_GROUPS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  cla_add_pipe_if.slave bus
);
  localparam int NGROUP = WIDTH / 4;
  localparam int NSTAGE = NGROUP / STAGE_GROUPS;
  localparam int BPS    = 4 * STAGE_GROUPS;   // result bits per stage

  // 4-bit lookahead group: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic       ci);
    logic [3:0] p, g, c;
    p    = a ^ b;
    g    = a & b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
            (p[3] & p[2] & p[1] & g[0]) | ((&p) & ci),
            p ^ c};
  endfunction

  // Whole pipeline moves in lock-step; a held result freezes every stage.
  logic advance;
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  // Subtract folds into the add: A - B - c_i = A + ~B + !c_i.
  logic [WIDTH-1:0] fe_b;
  logic             fe_c;
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    fe_b = bus.in_b;
    fe_c = bus.c_i;
    if (bus.sub) begin
      fe_b = ~bus.in_b;
      fe_c = ~bus.c_i;
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int LO  = k * BPS;        // first result bit of this stage
    localparam int OPW = WIDTH - LO;     // operand bits still unresolved

    logic                  v_in;
    logic                  c_in;
    logic [OPW-1:0]        a_in;
    logic [OPW-1:0]        b_in;
    logic [BPS-1:0]        grp_s;
    logic [STAGE_GROUPS:0] cy;
    logic [LO+BPS-1:0]     s_d;
    logic                  v_r;
    logic                  c_r;
    logic [LO+BPS-1:0]     s_r;

    if (k == 0) begin : g_src
      assign v_in = bus.in_valid;
      assign c_in = fe_c;
      assign a_in = bus.in_a;
      assign b_in = fe_b;
      assign s_d  = grp_s;
    end else begin : g_src
      assign v_in = g_stage[k-1].v_r;
      assign c_in = g_stage[k-1].c_r;
      assign a_in = g_stage[k-1].g_fwd.a_r;
      assign b_in = g_stage[k-1].g_fwd.b_r;
      assign s_d  = {grp_s, g_stage[k-1].s_r};
    end

    // Group carries ripple through the STAGE_GROUPS groups of this stage.
    assign cy[0] = c_in;
    for (genvar j = 0; j < STAGE_GROUPS; j++) begin : g_grp
      assign {cy[j+1], grp_s[j*4 +: 4]} = cla4(a_in[j*4 +: 4], b_in[j*4 +: 4], cy[j]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: datapath bits are reset too, so out/c_o/ovf read 0 during reset.
      if (!rst_n) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= '0;
      end else if (advance) begin
        // NOTE: non-blocking so every stage samples its predecessor's old value.
        v_r <= v_in;
        c_r <= cy[STAGE_GROUPS];
        s_r <= s_d;
      end
    end

    if (k < NSTAGE - 1) begin : g_fwd
      logic [OPW-BPS-1:0] a_r;
      logic [OPW-BPS-1:0] b_r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (advance) begin
          a_r <= a_in[OPW-1:BPS];
          b_r <= b_in[OPW-1:BPS];
        end
      end
    end else begin : g_last
      // Overflow: operands agree in sign but the sum's sign differs.
      logic ovf_r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (advance) begin
          ovf_r <= (a_in[BPS-1] == b_in[BPS-1]) && (grp_s[BPS-1] != a_in[BPS-1]);
        end
      end
    end
  end

  assign bus.out_valid = g_stage[NSTAGE-1].v_r;
  assign bus.out       = g_stage[NSTAGE-1].s_r;
  assign bus.c_o       = g_stage[NSTAGE-1].c_r;
  assign bus.ovf       = g_stage[NSTAGE-1].g_last.ovf_r;
endmodule

// File: tb/tb_cla_add_pipe.sv
// tb_cla_add_pipe: self-checking bench for cla_add_pipe.
// Main DUT: WIDTH=16, STAGE_GROUPS=1 (4 stages). Four extra 32-bit instances
// with STAGE_GROUPS 1/2/4/8 share a second stimulus stream.
// Expected values come from integer arithmetic on the operation's meaning
// (A+B+c_i or A-B-c_i, unsigned carry/borrow, signed range overflow).
module tb_cla_add_pipe;
  localparam int W  = 16;
  localparam int NS = 4;
  localparam int SW_OPS = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cla_add_pipe_if #(.WIDTH(W)) dif();
  cla_add_pipe #(.WIDTH(W), .STAGE_GROUPS(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(dif.slave)
  );

  // Parameter sweep instances.
  logic        sw_valid, sw_ci, sw_sub;
  logic [31:0] sw_a, sw_b;
  logic        sw_ov  [4];
  logic [31:0] sw_out [4];
  logic        sw_co  [4];
  logic        sw_ovf [4];
  for (genvar g = 0; g < 4; g++) begin : g_sw
    cla_add_pipe_if #(.WIDTH(32)) sif();
    assign sif.in_valid  = sw_valid;
    assign sif.in_a      = sw_a;
    assign sif.in_b      = sw_b;
    assign sif.c_i       = sw_ci;
    assign sif.sub       = sw_sub;
    assign sif.out_ready = 1'b1;
    cla_add_pipe #(.WIDTH(32), .STAGE_GROUPS(1 << g)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(sif.slave)
    );
    assign sw_ov[g]  = sif.out_valid;
    assign sw_out[g] = sif.out;
    assign sw_co[g]  = sif.c_o;
    assign sw_ovf[g] = sif.ovf;
  end

  typedef struct {
    logic [31:0] out;
    logic        c_o;
    logic        ovf;
    int          acc_edge;
  } exp_t;

  exp_t exp_q[$];
  int   n_cons   = 0;
  int   last_lat = 0;

  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic ci, logic sub);
    longint m, half, ua, ub, sa, sb, cl, r, sr;
    exp_t e;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    cl   = ci ? 1 : 0;
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sb   = (ub >= half) ? ub - (m + 1) : ub;
    if (sub) begin
      r     = ua - ub - cl;
      e.c_o = (ua >= ub + cl);
      sr    = sa - sb - cl;
    end else begin
      r     = ua + ub + cl;
      e.c_o = ((r >> w) & 1) != 0;
      sr    = sa + sb + cl;
    end
    e.out      = 32'(r & m);
    e.ovf      = (sr >= half) || (sr < -half);
    e.acc_edge = 0;
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(logic v, logic [W-1:0] a, logic [W-1:0] b, logic ci, logic sub);
    dif.in_valid = v;
    dif.in_a     = a;
    dif.in_b     = b;
    dif.c_i      = ci;
    dif.sub      = sub;
  endtask

  task automatic drive_rand();
    drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // One clock of the main DUT: log accept/consume, advance, check the output.
  task automatic tick();
    exp_t e;
    #1;
    if (dif.in_valid && dif.in_ready) begin
      e = model(W, 32'(dif.in_a), 32'(dif.in_b), dif.c_i, dif.sub);
      e.acc_edge = cyc + 1;
      exp_q.push_back(e);
    end
    if (dif.out_valid && dif.out_ready) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      n_cons++;
    end
    @(posedge clk);
    @(negedge clk);
    if (dif.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 32'd1, 32'd0);
      end else begin
        check("out", 32'(dif.out), exp_q[0].out);
        check("c_o", 32'(dif.c_o), 32'(exp_q[0].c_o));
        check("ovf", 32'(dif.ovf), 32'(exp_q[0].ovf));
        last_lat = cyc - exp_q[0].acc_edge + 1;
      end
    end
  endtask

  task automatic run_dir(string tag, logic [W-1:0] a, logic [W-1:0] b, logic ci, logic sub,
                         logic [W-1:0] eo, logic eco, logic eov);
    drive(1'b1, a, b, ci, sub);
    tick();
    dif.in_valid = 1'b0;
    for (int i = 0; i < 20 && !dif.out_valid; i++) tick();
    check({tag, "_valid"}, 32'(dif.out_valid), 32'd1);
    check({tag, "_out"},   32'(dif.out), 32'(eo));
    check({tag, "_c_o"},   32'(dif.c_o), 32'(eco));
    check({tag, "_ovf"},   32'(dif.ovf), 32'(eov));
    check({tag, "_lat"},   32'(last_lat), 32'(NS));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held_out;
    logic         held_co, held_ovf;
    int           n0, e0;
    exp_t         sw_exp [SW_OPS];
    int           sw_idx [4];
    int           sw_first [4];

    rst_n         = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    dif.out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_out_valid", 32'(dif.out_valid), 32'd0);
    check("rst_out",       32'(dif.out), 32'd0);
    check("rst_c_o",       32'(dif.c_o), 32'd0);
    check("rst_ovf",       32'(dif.ovf), 32'd0);
    check("rst_in_ready",  32'(dif.in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed add / subtract corner cases
    run_dir("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_dir("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_dir("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_dir("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_dir("sub_borr",  16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_dir("add_cin",   16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);

    // Streaming: 100 back-to-back ops, one result per cycle
    n0 = n_cons;
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      tick();
      if (i == NS - 1) begin
        check("stream_first_valid", 32'(dif.out_valid), 32'd1);
        check("stream_first_lat",   32'(last_lat), 32'(NS));
      end
    end
    dif.in_valid = 1'b0;
    repeat (NS) tick();
    check("stream_count", 32'(n_cons - n0), 32'd100);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure with a full pipeline
    for (int i = 0; i < NS; i++) begin
      drive_rand();
      tick();
    end
    check("bp_full", 32'(dif.out_valid), 32'd1);
    held_out = dif.out;
    held_co  = dif.c_o;
    held_ovf = dif.ovf;
    dif.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_rand();
      #1;
      check("bp_in_ready", 32'(dif.in_ready), 32'd0);
      tick();
      check("bp_hold_valid", 32'(dif.out_valid), 32'd1);
      check("bp_hold_out",   32'(dif.out), 32'(held_out));
      check("bp_hold_c_o",   32'(dif.c_o), 32'(held_co));
      check("bp_hold_ovf",   32'(dif.ovf), 32'(held_ovf));
    end
    dif.out_ready = 1'b1;
    dif.in_valid  = 1'b0;
    n0 = n_cons;
    repeat (NS) tick();
    check("bp_drain_count", 32'(n_cons - n0), 32'(NS));
    check("bp_drain_empty", 32'(dif.out_valid), 32'd0);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-flight
    for (int i = 0; i < NS; i++) begin
      drive_rand();
      tick();
    end
    dif.in_valid = 1'b0;
    check("mid_before_rst_valid", 32'(dif.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    32'(dif.out_valid), 32'd0);
    check("mid_rst_out",      32'(dif.out), 32'd0);
    check("mid_rst_c_o",      32'(dif.c_o), 32'd0);
    check("mid_rst_ovf",      32'(dif.ovf), 32'd0);
    check("mid_rst_in_ready", 32'(dif.in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = n_cons;
    repeat (8) tick();
    check("mid_no_stale", 32'(n_cons - n0), 32'd0);
    run_dir("post_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

    // Parameter sweep, WIDTH=32
    for (int g = 0; g < 4; g++) begin
      sw_idx[g]   = 0;
      sw_first[g] = -1;
    end
    e0 = 0;
    for (int c = 0; c < SW_OPS + 12; c++) begin
      if (c < SW_OPS) begin
        sw_valid = 1'b1;
        sw_a     = $urandom;
        sw_b     = $urandom;
        sw_ci    = 1'($urandom);
        sw_sub   = 1'($urandom);
        if (c == 1) begin
          sw_a = 32'hFFFF_FFFF; sw_b = 32'h0000_0001; sw_ci = 1'b0; sw_sub = 1'b0;
        end
        if (c == 2) begin
          sw_a = 32'h8000_0000; sw_b = 32'h0000_0001; sw_ci = 1'b0; sw_sub = 1'b1;
        end
        sw_exp[c] = model(32, sw_a, sw_b, sw_ci, sw_sub);
        if (c == 0) e0 = cyc + 1;
      end else begin
        sw_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (sw_ov[g]) begin
          if (sw_idx[g] == 0) sw_first[g] = cyc;
          if (sw_idx[g] < SW_OPS) begin
            check($sformatf("sw%0d_out", g), sw_out[g], sw_exp[sw_idx[g]].out);
            check($sformatf("sw%0d_c_o", g), 32'(sw_co[g]), 32'(sw_exp[sw_idx[g]].c_o));
            check($sformatf("sw%0d_ovf", g), 32'(sw_ovf[g]), 32'(sw_exp[sw_idx[g]].ovf));
          end else begin
            check($sformatf("sw%0d_extra", g), 32'd1, 32'd0);
          end
          sw_idx[g]++;
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      check($sformatf("sw%0d_count", g), 32'(sw_idx[g]), 32'(SW_OPS));
      check($sformatf("sw%0d_lat", g), 32'(sw_first[g] - e0 + 1), 32'(8 >> g));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
